// File: rtl/fft_sample_loader.sv
// FFT input stage: loads one frame of complex samples into the sample RAM in
// bit-reversed order and otherwise passes the FFT engine's RAM port through.
module fft_sample_loader #(
    parameter int N_LOG2 = 11,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_re,
    input  logic [DATA_W-1:0]     s_im,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  eng_ce,
    input  logic                  eng_oce,
    input  logic                  eng_wre,
    input  logic [N_LOG2-1:0]     eng_ad,
    input  logic [2*DATA_W-1:0]   eng_din,
    output logic                  ram_ce,
    output logic                  ram_oce,
    output logic                  ram_wre,
    output logic [N_LOG2-1:0]     ram_ad,
    output logic [2*DATA_W-1:0]   ram_din
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N_LOG2-1:0]     cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [N_LOG2-1:0]     wr_ad_q, wr_ad_d;
    logic [2*DATA_W-1:0]   wr_din_q, wr_din_d;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_LOG2; i++) begin
            r[i] = x[N_LOG2-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_ad_q  <= '0;
            wr_din_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            wr_ad_q  <= wr_ad_d;
            wr_din_q <= wr_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_ad_d    = wr_ad_q;
        wr_din_d   = wr_din_q;
        s_ready    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    wr_en_d  = 1'b1;
                    wr_ad_d  = bitrev(cnt_q);
                    wr_din_d = {s_re, s_im};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The last sample's registered write drains during DONE, hence the mux keys on busy.
    always_comb begin
        if (busy) begin
            ram_ce  = wr_en_q;
            ram_oce = 1'b0;
            ram_wre = wr_en_q;
            ram_ad  = wr_ad_q;
            ram_din = wr_din_q;
        end else begin
            ram_ce  = eng_ce;
            ram_oce = eng_oce;
            ram_wre = eng_wre;
            ram_ad  = eng_ad;
            ram_din = eng_din;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader with a behavioural RAM and reference image.
module tb_fft_sample_loader;

    localparam int NL = 11;
    localparam int N  = 2048;

    logic        clk = 1'b0;
    logic        reset, start, s_valid;
    logic [15:0] s_re, s_im;
    logic        s_ready, busy, frame_done;
    logic        eng_ce, eng_oce, eng_wre;
    logic [10:0] eng_ad;
    logic [31:0] eng_din;
    logic        ram_ce, ram_oce, ram_wre;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;

    fft_sample_loader #(.N_LOG2(NL), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_re(s_re), .s_im(s_im), .s_ready(s_ready),
        .busy(busy), .frame_done(frame_done),
        .eng_ce(eng_ce), .eng_oce(eng_oce), .eng_wre(eng_wre),
        .eng_ad(eng_ad), .eng_din(eng_din),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with synchronous read
    logic [31:0] mem [N];
    logic [31:0] rd_q;
    logic [10:0] log_ad  [$];
    logic [31:0] log_din [$];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                log_ad.push_back(ram_ad);
                log_din.push_back(ram_din);
            end else if (ram_oce) begin
                rd_q <= mem[ram_ad];
            end
        end
    end

    int nchecks = 0;
    int nfail   = 0;

    logic [15:0] re_a [N];
    logic [15:0] im_a [N];
    logic [31:0] exp_mem [N];

    int done_cnt, done_off, ready_viol, busy_viol, timeout, post_busy;

    function automatic int rev(input int x);
        int r, v;
        r = 0;
        v = x;
        for (int b = 0; b < NL; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic fill_count();
        for (int i = 0; i < N; i++) begin
            re_a[i] = 16'(i);
            im_a[i] = 16'(-i);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            re_a[i] = 16'($urandom);
            im_a[i] = 16'($urandom);
        end
    endtask

    task automatic build_exp();
        for (int i = 0; i < N; i++) exp_mem[rev(i)] = {re_a[i], im_a[i]};
    endtask

    function automatic int mem_errors();
        int e;
        e = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) e++;
        return e;
    endfunction

    // Stimulus only: pulses start, streams samples and records observations.
    task automatic drive_frame(input int n_lim, input int duty, input bit eng_noise,
                               input bit start_noise);
        int idx, first_t, t;
        bit v, sr;
        done_cnt = 0; done_off = -1; ready_viol = 0; busy_viol = 0;
        timeout = 1; post_busy = -1;
        idx = 0; first_t = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (eng_noise) begin
            eng_ce = 1'b1; eng_wre = 1'b1; eng_oce = 1'b0;
        end
        for (t = 0; t < 20000; t++) begin
            sr = s_ready;
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_off = t - first_t;
                if (busy !== 1'b1 || s_ready !== 1'b0) busy_viol++;
                timeout = 0;
                break;
            end
            if (busy !== 1'b1 || s_ready !== 1'b1) ready_viol++;
            if (idx >= n_lim) begin
                s_valid = 1'b0;
                start   = 1'b0;
                timeout = 0;
                break;
            end
            v = ($urandom_range(99) < duty);
            s_valid = v;
            s_re = re_a[idx];
            s_im = im_a[idx];
            if (eng_noise) begin
                eng_ad  = 11'($urandom);
                eng_din = $urandom;
            end
            start = start_noise && ($urandom_range(99) < 10);
            if (v && sr) begin
                if (idx == 0) first_t = t;
                idx++;
            end
            @(negedge clk);
        end
        if (done_cnt > 0) begin
            s_valid = 1'b0;
            eng_ce = 1'b0; eng_wre = 1'b0; eng_oce = 1'b0;
            start = start_noise;
            @(negedge clk);
            start = 1'b0;
            post_busy = int'(busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
        eng_ce = 1'b0; eng_oce = 1'b0; eng_wre = 1'b0; eng_ad = '0; eng_din = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nchecks++;
        if ({busy, s_ready, frame_done} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_outputs busy/s_ready/frame_done got %b want 000",
                     {busy, s_ready, frame_done});
        end
        eng_ce = 1'b1; eng_oce = 1'b1; eng_ad = 11'h3C1; eng_din = 32'h1234_5678;
        #1;
        nchecks++;
        if ({ram_ce, ram_oce, ram_wre, ram_ad, ram_din} !== {3'b110, 11'h3C1, 32'h1234_5678}) begin
            nfail++;
            $display("FAIL reset_passthrough ram got %b_%h_%h want 110_3c1_12345678",
                     {ram_ce, ram_oce, ram_wre}, ram_ad, ram_din);
        end
        eng_ce = 1'b0; eng_oce = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        eng_ce = 1'b1; eng_wre = 1'b1; eng_oce = 1'b0; eng_ad = 11'd5; eng_din = 32'hA5A5_5A5A;
        #1;
        nchecks++;
        if ({ram_ce, ram_wre, ram_ad, ram_din} !== {2'b11, 11'd5, 32'hA5A5_5A5A}) begin
            nfail++;
            $display("FAIL pass_write_comb got ce/wre=%b ad=%0d din=%h want 11 5 a5a55a5a",
                     {ram_ce, ram_wre}, ram_ad, ram_din);
        end
        @(negedge clk);
        nchecks++;
        if (mem[5] !== 32'hA5A5_5A5A) begin
            nfail++;
            $display("FAIL pass_write_ram mem[5]=%h want a5a55a5a", mem[5]);
        end
        eng_wre = 1'b0; eng_oce = 1'b1; eng_din = '0;
        #1;
        nchecks++;
        if ({ram_ce, ram_oce, ram_wre, ram_ad} !== {3'b110, 11'd5}) begin
            nfail++;
            $display("FAIL pass_read_comb got %b ad=%0d want 110 ad=5",
                     {ram_ce, ram_oce, ram_wre}, ram_ad);
        end
        @(negedge clk);
        nchecks++;
        if (rd_q !== 32'hA5A5_5A5A) begin
            nfail++;
            $display("FAIL pass_read_data got %h want a5a55a5a", rd_q);
        end
        eng_ce = 1'b0; eng_oce = 1'b0; eng_ad = '0;
    endtask

    task automatic test_full_frame();
        int e;
        fill_count();
        build_exp();
        drive_frame(N, 100, 1'b0, 1'b0);
        nchecks++;
        if (timeout != 0 || done_cnt != 1) begin
            nfail++;
            $display("FAIL full_done_count got %0d (timeout=%0d) want 1", done_cnt, timeout);
        end
        // frame_done lands on the 2049th cycle counting the first accept cycle as cycle 1
        nchecks++;
        if (done_off != 2048) begin
            nfail++;
            $display("FAIL full_done_latency got %0d want 2048", done_off);
        end
        nchecks++;
        if (mem[1024] !== 32'h0001_FFFF || mem[1536] !== 32'h0003_FFFD) begin
            nfail++;
            $display("FAIL full_spot_a mem[1024]=%h mem[1536]=%h want 0001ffff 0003fffd",
                     mem[1024], mem[1536]);
        end
        nchecks++;
        if (mem[2047] !== 32'h07FF_F801 || mem[0] !== 32'h0000_0000) begin
            nfail++;
            $display("FAIL full_spot_b mem[2047]=%h mem[0]=%h want 07fff801 00000000",
                     mem[2047], mem[0]);
        end
        e = mem_errors();
        nchecks++;
        if (e != 0) begin
            nfail++;
            $display("FAIL full_ram_image got %0d bad words want 0", e);
        end
        nchecks++;
        if (post_busy != 0 || ready_viol != 0 || busy_viol != 0) begin
            nfail++;
            $display("FAIL full_handshake post_busy=%0d ready_viol=%0d done_viol=%0d want 0 0 0",
                     post_busy, ready_viol, busy_viol);
        end
    endtask

    task automatic test_engine_blocked();
        int e;
        fill_random();
        build_exp();
        drive_frame(N, 90, 1'b1, 1'b0);
        e = mem_errors();
        nchecks++;
        if (timeout != 0 || done_cnt != 1 || e != 0) begin
            nfail++;
            $display("FAIL eng_blocked bad_words=%0d done=%0d want 0 1", e, done_cnt);
        end
    endtask

    task automatic test_gappy_valid();
        int e;
        fill_count();
        build_exp();
        drive_frame(N, 30, 1'b0, 1'b0);
        nchecks++;
        if (ready_viol != 0 || busy_viol != 0) begin
            nfail++;
            $display("FAIL gap_ready_busy load_viol=%0d done_viol=%0d want 0 0",
                     ready_viol, busy_viol);
        end
        e = mem_errors();
        nchecks++;
        if (timeout != 0 || done_cnt != 1 || e != 0) begin
            nfail++;
            $display("FAIL gap_ram_image bad_words=%0d done=%0d want 0 1", e, done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, e, stray;
        fill_random();
        drive_frame(100, 60, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        nchecks++;
        if ({busy, s_ready, frame_done, ram_wre} !== 4'b0000) begin
            nfail++;
            $display("FAIL midreset_outputs busy/s_ready/frame_done/ram_wre got %b want 0000",
                     {busy, s_ready, frame_done, ram_wre});
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0) stray++;
        end
        nchecks++;
        if (stray != 0) begin
            nfail++;
            $display("FAIL midreset_quiet got %0d active cycles want 0", stray);
        end
        fill_random();
        build_exp();
        base = log_ad.size();
        drive_frame(N, 80, 1'b0, 1'b0);
        nchecks++;
        if (log_ad.size() <= base) begin
            nfail++;
            $display("FAIL reload_first_write got no writes want ad=0");
        end else if (log_ad[base] !== 11'd0 || log_din[base] !== {re_a[0], im_a[0]}) begin
            nfail++;
            $display("FAIL reload_first_write got ad=%0d din=%h want ad=0 din=%h",
                     log_ad[base], log_din[base], {re_a[0], im_a[0]});
        end
        e = mem_errors();
        nchecks++;
        if (timeout != 0 || done_cnt != 1 || e != 0) begin
            nfail++;
            $display("FAIL reload_ram_image bad_words=%0d done=%0d want 0 1", e, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int stray;
        fill_count();
        drive_frame(N, 70, 1'b0, 1'b1);
        nchecks++;
        if (timeout != 0 || done_cnt != 1 || post_busy != 0) begin
            nfail++;
            $display("FAIL start_ignored done=%0d post_busy=%0d want 1 0", done_cnt, post_busy);
        end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_done !== 1'b0 || s_ready !== 1'b0) stray++;
        end
        nchecks++;
        if (stray != 0) begin
            nfail++;
            $display("FAIL start_no_second_load got %0d busy cycles want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_full_frame();
        test_engine_blocked();
        test_gappy_valid();
        test_reset_mid_frame();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
